// File: rtl/tetris_pkg.sv
// Shared definitions for the piece_drop slice of the 4x8 falling-block game.
// Board layout: bit 4r+c is row r (0 = top, 7 = bottom) and column c (0 = left).
// Contents: board geometry constants, edge masks, spawn masks, the FSM state
// encoding, the direction codes used by piece_shift_check, and a helper that
// maps a piece type to its spawn mask.
package tetris_pkg;

    localparam int BOARD_W  = 32;
    localparam int ROW_W    = 4;
    localparam int NUM_ROWS = 8;

    localparam logic [BOARD_W-1:0] COL0_MASK = 32'h1111_1111;
    localparam logic [BOARD_W-1:0] COL3_MASK = 32'h8888_8888;
    localparam logic [BOARD_W-1:0] ROW7_MASK = 32'hF000_0000;

    localparam logic [BOARD_W-1:0] SPAWN_SINGLE = 32'h0000_0002;
    localparam logic [BOARD_W-1:0] SPAWN_DOMINO = 32'h0000_0006;
    localparam logic [BOARD_W-1:0] SPAWN_SQUARE = 32'h0000_0066;
    localparam logic [BOARD_W-1:0] SPAWN_L      = 32'h0000_0062;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        LOCK = 2'd2,
        OVER = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2
    } dir_t;

    function automatic logic [BOARD_W-1:0] spawn_mask(input logic [1:0] kind);
        logic [BOARD_W-1:0] mask;
        case (kind)
            2'b00:   mask = SPAWN_SINGLE;
            2'b01:   mask = SPAWN_DOMINO;
            2'b10:   mask = SPAWN_SQUARE;
            default: mask = SPAWN_L;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/piece_drop_if.sv
// Bus bundle between the piece source / controls, piece_drop and the clear stage.
//   spawn_valid/spawn_ready/spawn_piece/board_in : spawn handshake + payload
//   move_left/move_right/soft_drop               : player controls
//   board_out                                    : display board (settled | piece)
//   lock_valid/lock_ready/locked_board           : handoff to clear_redraw
//   game_over                                    : sticky collision flag
// Modport slave is the piece_drop side, master is the environment side.
interface piece_drop_if;
    import tetris_pkg::*;

    logic                 spawn_valid;
    logic                 spawn_ready;
    logic [1:0]           spawn_piece;
    logic [BOARD_W-1:0]   board_in;
    logic                 move_left;
    logic                 move_right;
    logic                 soft_drop;
    logic [BOARD_W-1:0]   board_out;
    logic                 lock_valid;
    logic                 lock_ready;
    logic [BOARD_W-1:0]   locked_board;
    logic                 game_over;

    modport slave (
        input  spawn_valid, spawn_piece, board_in,
        input  move_left, move_right, soft_drop,
        input  lock_ready,
        output spawn_ready, board_out, lock_valid, locked_board, game_over
    );

    modport master (
        output spawn_valid, spawn_piece, board_in,
        output move_left, move_right, soft_drop,
        output lock_ready,
        input  spawn_ready, board_out, lock_valid, locked_board, game_over
    );

endinterface

// File: rtl/piece_shift_check.sv
// Combinational move checker for one direction.
//   piece   in  32  current piece mask
//   settled in  32  settled board
//   dir     in  2   0 left, 1 right, 2 down
//   cand    out 32  piece mask after the move
//   legal   out 1   move stays on the board and hits no settled cell
module piece_shift_check
    import tetris_pkg::*;
(
    input  logic [BOARD_W-1:0] piece,
    input  logic [BOARD_W-1:0] settled,
    input  logic [1:0]         dir,
    output logic [BOARD_W-1:0] cand,
    output logic               legal
);

    logic on_board;

    always_comb begin
        cand     = piece;
        on_board = 1'b0;
        case (dir)
            DIR_LEFT: begin
                // Any cell in column 0 would wrap into column 3 of the row above.
                cand     = piece >> 1;
                on_board = ((piece & COL0_MASK) == '0);
            end
            DIR_RIGHT: begin
                cand     = piece << 1;
                on_board = ((piece & COL3_MASK) == '0);
            end
            DIR_DOWN: begin
                cand     = piece << ROW_W;
                on_board = ((piece & ROW7_MASK) == '0);
            end
            default: begin
                cand     = piece;
                on_board = 1'b0;
            end
        endcase
        legal = on_board && ((cand & settled) == '0);
    end

endmodule

// File: rtl/piece_drop.sv
// Active-piece engine feeding clear_redraw on the 4x8 board.
//   clka  in  single clock, all state on posedge
//   rst   in  synchronous active-high reset
//   bus   piece_drop_if.slave: spawn handshake, controls, display board,
//         lock handshake and game_over.
// A spawned piece falls one row every DROP_CYCLES cycles (or immediately on
// soft_drop). When it cannot fall further the merged board is offered on
// locked_board until the clear stage accepts it.
module piece_drop
    import tetris_pkg::*;
#(
    parameter int DROP_CYCLES = 8
) (
    input  logic         clka,
    input  logic         rst,
    piece_drop_if.slave  bus
);

    localparam int               CNT_W    = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DROP_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [BOARD_W-1:0] settled_reg, settled_next;
    logic [BOARD_W-1:0] piece_reg, piece_next;
    logic [BOARD_W-1:0] board_out_reg, board_out_next;
    logic [BOARD_W-1:0] locked_reg, locked_next;
    logic [BOARD_W-1:0] new_mask;
    logic               drop_now;

    // One checker per direction, indexed by the dir_t code.
    logic [BOARD_W-1:0] cand  [3];
    logic               legal [3];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_check
            piece_shift_check u_check (
                .piece   (piece_reg),
                .settled (settled_reg),
                .dir     (2'(gi)),
                .cand    (cand[gi]),
                .legal   (legal[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        settled_next = settled_reg;
        piece_next   = piece_reg;
        locked_next  = locked_reg;
        drop_now     = 1'b0;
        new_mask     = spawn_mask(bus.spawn_piece);

        case (state_reg)
            IDLE: begin
                if (bus.spawn_valid) begin
                    settled_next = bus.board_in;
                    piece_next   = new_mask;
                    if ((new_mask & bus.board_in) != '0) begin
                        state_next = OVER;
                    end else begin
                        state_next = FALL;
                        cnt_next   = '0;
                    end
                end
            end
            FALL: begin
                drop_now = bus.soft_drop || (cnt_reg == CNT_LAST);
                cnt_next = drop_now ? '0 : cnt_reg + 1'b1;
                if (drop_now) begin
                    // Gravity wins over lateral input in the same cycle.
                    if (legal[DIR_DOWN]) begin
                        piece_next = cand[DIR_DOWN];
                    end else begin
                        locked_next = settled_reg | piece_reg;
                        state_next  = LOCK;
                    end
                end else if (bus.move_left && !bus.move_right && legal[DIR_LEFT]) begin
                    piece_next = cand[DIR_LEFT];
                end else if (bus.move_right && !bus.move_left && legal[DIR_RIGHT]) begin
                    piece_next = cand[DIR_RIGHT];
                end
            end
            LOCK: begin
                if (bus.lock_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                // OVER: frozen until reset.
            end
        endcase

        // After a colliding spawn the display shows the delivered board only.
        board_out_next = (state_reg == OVER) ? settled_reg : (settled_reg | piece_reg);
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            settled_reg   <= '0;
            piece_reg     <= '0;
            board_out_reg <= '0;
            locked_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            settled_reg   <= settled_next;
            piece_reg     <= piece_next;
            board_out_reg <= board_out_next;
            locked_reg    <= locked_next;
        end
    end

    assign bus.spawn_ready  = (state_reg == IDLE);
    assign bus.lock_valid   = (state_reg == LOCK);
    assign bus.game_over    = (state_reg == OVER);
    assign bus.board_out    = board_out_reg;
    assign bus.locked_board = locked_reg;

endmodule
